// File: rtl/coproc_arbiter_if.sv
// coproc_arbiter_if: channel request/ack bus plus downstream coprocessor handshake
interface coproc_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_ack;
  logic [NCH-1:0]    ch_err;
  logic [NCH*DW-1:0] ch_data;
  logic              co_req;
  logic [AW-1:0]     co_addr;
  logic              co_ack;
  logic [DW-1:0]     co_data;
  modport slave (
    input  ch_req, ch_addr, co_ack, co_data,
    output ch_ack, ch_err, ch_data, co_req, co_addr
  );
  modport master (
    output ch_req, ch_addr, co_ack, co_data,
    input  ch_ack, ch_err, ch_data, co_req, co_addr
  );
endinterface

// File: rtl/coproc_arbiter.sv
// coproc_arbiter: round-robin arbiter sharing one coprocessor among NCH channels, with timeout
module coproc_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  coproc_arbiter_if.slave  bus,
  output logic             busy_o,
  output logic [CW-1:0]    timeout_count_o
);
  localparam int GW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  state_e            state_q, state_d;
  logic [GW-1:0]     g_q, g_d, rr_q, rr_d, pick, idx;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              co_req_q, co_req_d, busy_q, busy_d, hit;
  logic [AW-1:0]     co_addr_q, co_addr_d;
  logic [NCH-1:0]    ack_q, ack_d, err_q, err_d;
  logic [NCH*DW-1:0] data_q, data_d;
  logic [CW-1:0]     tc_q, tc_d;
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    co_req_d  = co_req_q;
    co_addr_d = co_addr_q;
    ack_d     = ack_q;
    err_d     = err_q;
    data_d    = data_q;
    tc_d      = tc_q;
    hit       = 1'b0;
    pick      = '0;
    idx       = '0;
    // first requester at or after rr_q, wrapping modulo NCH
    for (int i = 0; i < NCH; i++) begin
      idx = GW'((int'(rr_q) + i) % NCH);
      if (!hit && bus.ch_req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
    case (state_q)
      IDLE: if (hit) begin
        g_d       = pick;
        co_addr_d = bus.ch_addr[pick*AW +: AW];
        co_req_d  = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: if (bus.co_ack) begin
        data_d[g_q*DW +: DW] = bus.co_data;
        ack_d[g_q]           = 1'b1;
        co_req_d             = 1'b0;
        state_d              = DONE;
      end else if (cnt_q == TW'(TIMEOUT - 1)) begin
        ack_d[g_q] = 1'b1;
        err_d[g_q] = 1'b1;
        co_req_d   = 1'b0;
        tc_d       = &tc_q ? tc_q : tc_q + 1'b1;
        state_d    = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        ack_d   = '0;
        err_d   = '0;
        rr_d    = (g_q == GW'(NCH - 1)) ? '0 : g_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      g_q       <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      co_req_q  <= 1'b0;
      co_addr_q <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      data_q    <= '0;
      tc_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      co_req_q  <= co_req_d;
      co_addr_q <= co_addr_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      data_q    <= data_d;
      tc_q      <= tc_d;
      busy_q    <= busy_d;
    end
  end
  assign bus.ch_ack      = ack_q;
  assign bus.ch_err      = err_q;
  assign bus.ch_data     = data_q;
  assign bus.co_req      = co_req_q;
  assign bus.co_addr     = co_addr_q;
  assign busy_o          = busy_q;
  assign timeout_count_o = tc_q;
endmodule

// File: tb/tb_coproc_arbiter.sv
// tb_coproc_arbiter: directed checks of grant order, timeout, reset and ack paths
module tb_coproc_arbiter;
  logic       clk, rst, busy;
  logic [7:0] tcount;
  int         checks = 0;
  int         failures = 0;
  int         hi;
  logic       seen;
  logic [1:0] a, e;
  coproc_arbiter_if #(.NCH(2), .AW(32), .DW(32)) bus ();
  coproc_arbiter #(.NCH(2), .AW(32), .DW(32), .TIMEOUT(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy_o(busy), .timeout_count_o(tcount)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.ch_req = '0; bus.ch_addr = '0; bus.co_ack = 1'b0; bus.co_data = '0; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_co_req", bus.co_req, 0);
    chk("rst_co_addr", bus.co_addr, 0);
    chk("rst_ack", bus.ch_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tc", tcount, 0);
    rst = 1'b0;
    // single request, ack three cycles after co_req rises
    bus.ch_addr = {32'h0, 32'h100}; bus.ch_req = 2'b01;
    @(negedge clk);
    chk("t1_co_req", bus.co_req, 1);
    chk("t1_co_addr", bus.co_addr, 32'h100);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    bus.co_ack = 1'b1; bus.co_data = 32'hABCD1234;
    @(negedge clk);
    chk("t1_ack", bus.ch_ack, 2'b01);
    chk("t1_err", bus.ch_err, 2'b00);
    chk("t1_data0", bus.ch_data[31:0], 32'hABCD1234);
    chk("t1_co_req_low", bus.co_req, 0);
    bus.co_ack = 1'b0; bus.ch_req = 2'b00;
    @(negedge clk);
    chk("t1_ack_clr", bus.ch_ack, 2'b00);
    chk("t1_idle", busy, 0);
    // both channels from reset: ch0 then ch1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ch_addr = {32'h300, 32'h200}; bus.ch_req = 2'b11;
    @(negedge clk);
    chk("t2_first_ch0", bus.co_addr, 32'h200);
    bus.co_ack = 1'b1; bus.co_data = 32'h11;
    @(negedge clk);
    chk("t2_ack0", bus.ch_ack, 2'b01);
    bus.co_ack = 1'b0; bus.ch_req = 2'b10;
    @(negedge clk);
    chk("t2_done_gap", bus.ch_ack, 2'b00);
    @(negedge clk);
    chk("t2_then_ch1", bus.co_addr, 32'h300);
    bus.co_ack = 1'b1; bus.co_data = 32'h22;
    @(negedge clk);
    chk("t2_ack1", bus.ch_ack, 2'b10);
    chk("t2_data", bus.ch_data, {32'h22, 32'h11});
    bus.co_ack = 1'b0; bus.ch_req = 2'b00;
    @(negedge clk);
    // serve ch0 alone, then simultaneous request must go to ch1
    bus.ch_req = 2'b01;
    @(negedge clk);
    chk("t2b_ch0", bus.co_addr, 32'h200);
    bus.co_ack = 1'b1; bus.co_data = 32'h33;
    @(negedge clk);
    chk("t2b_ack0", bus.ch_ack, 2'b01);
    bus.co_ack = 1'b0; bus.ch_req = 2'b00;
    @(negedge clk);
    bus.ch_req = 2'b11;
    @(negedge clk);
    chk("t2b_rr_ch1", bus.co_addr, 32'h300);
    bus.co_ack = 1'b1; bus.co_data = 32'h44;
    @(negedge clk);
    chk("t2b_ack1", bus.ch_ack, 2'b10);
    bus.co_ack = 1'b0; bus.ch_req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk("t2b_ch0_next", bus.co_addr, 32'h200);
    bus.co_ack = 1'b1; bus.co_data = 32'h55;
    @(negedge clk);
    chk("t2b_ack0_next", bus.ch_ack, 2'b01);
    chk("t2b_data", bus.ch_data, {32'h44, 32'h55});
    bus.co_ack = 1'b0; bus.ch_req = 2'b00;
    @(negedge clk);
    // ch1 timeout with no co_ack
    bus.ch_addr = {32'h500, 32'h200}; bus.ch_req = 2'b10; bus.co_data = 32'hDEADBEEF;
    hi = 0; seen = 1'b0; a = '0; e = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.co_req) hi++;
      if (bus.ch_ack != 2'b00 && !seen) begin
        seen = 1'b1; a = bus.ch_ack; e = bus.ch_err; bus.ch_req = 2'b00;
      end
    end
    chk("t3_co_req_cycles", hi, 8);
    chk("t3_ack", a, 2'b10);
    chk("t3_err", e, 2'b10);
    chk("t3_tc", tcount, 1);
    chk("t3_data_kept", bus.ch_data, {32'h44, 32'h55});
    chk("t3_idle", busy, 0);
    // co_ack on the final wait cycle wins over timeout
    bus.ch_addr = {32'h500, 32'h600}; bus.ch_req = 2'b01;
    repeat (8) @(negedge clk);
    chk("t4_still_waiting", bus.co_req, 1);
    bus.co_ack = 1'b1; bus.co_data = 32'h12345678;
    @(negedge clk);
    chk("t4_ack", bus.ch_ack, 2'b01);
    chk("t4_err", bus.ch_err, 2'b00);
    chk("t4_data0", bus.ch_data[31:0], 32'h12345678);
    chk("t4_tc", tcount, 1);
    bus.co_ack = 1'b0; bus.ch_req = 2'b00;
    @(negedge clk);
    // reset during WAIT, late co_ack ignored
    bus.ch_addr = {32'h700, 32'h600}; bus.ch_req = 2'b10;
    @(negedge clk);
    chk("t5_co_addr", bus.co_addr, 32'h700);
    rst = 1'b1; bus.ch_req = 2'b00;
    @(negedge clk);
    rst = 1'b0; bus.co_ack = 1'b1;
    chk("t5_co_req", bus.co_req, 0);
    chk("t5_co_addr0", bus.co_addr, 0);
    chk("t5_data0", bus.ch_data, 0);
    chk("t5_tc", tcount, 0);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    chk("t5_no_ack", bus.ch_ack, 2'b00);
    chk("t5_busy_after", busy, 0);
    chk("t5_co_req_after", bus.co_req, 0);
    bus.co_ack = 1'b0;
    // request dropped mid-WAIT still completes
    bus.ch_addr = {32'h0, 32'h800}; bus.ch_req = 2'b01;
    @(negedge clk);
    chk("t6_co_addr", bus.co_addr, 32'h800);
    bus.ch_req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    bus.co_ack = 1'b1; bus.co_data = 32'hCAFEF00D;
    @(negedge clk);
    chk("t6_ack", bus.ch_ack, 2'b01);
    chk("t6_data", bus.ch_data, {32'h0, 32'hCAFEF00D});
    bus.co_ack = 1'b0;
    @(negedge clk);
    chk("t6_idle", busy, 0);
    // requester still high at the ack edge: no double grant
    bus.ch_addr = {32'h0, 32'h900}; bus.ch_req = 2'b01;
    @(negedge clk);
    chk("t7_co_addr", bus.co_addr, 32'h900);
    bus.co_ack = 1'b1; bus.co_data = 32'h9999;
    @(negedge clk);
    chk("t7_ack", bus.ch_ack, 2'b01);
    bus.co_ack = 1'b0;
    @(negedge clk);
    chk("t7_done_ack_clr", bus.ch_ack, 2'b00);
    bus.ch_req = 2'b00;
    @(negedge clk);
    chk("t7_no_regrant_req", bus.co_req, 0);
    chk("t7_no_regrant_busy", busy, 0);
    bus.ch_addr = {32'h0, 32'hA00}; bus.ch_req = 2'b01;
    @(negedge clk);
    chk("t7_new_grant", bus.co_addr, 32'hA00);
    bus.co_ack = 1'b1; bus.co_data = 32'hA;
    @(negedge clk);
    chk("t7_new_ack", bus.ch_ack, 2'b01);
    chk("t7_new_data", bus.ch_data[31:0], 32'hA);
    bus.co_ack = 1'b0; bus.ch_req = 2'b00;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coproc_arbiter.md
COPROC_ARBITER -- requirements
Module: coproc_arbiter

Interface
REQ-001 Parameter NCH, default 2, number of requesting channels (1..16); ch 0 = logic engine, ch 1 = Python executor.
REQ-002 Parameter AW, default 32, request address width.
REQ-003 Parameter DW, default 32, result data width.
REQ-004 Parameter TIMEOUT, default 255, max cycles co_req is held waiting for co_ack (>=1).
REQ-005 Parameter CW, default 8, width of timeout_count.
REQ-006 Port clk  in  1  single clock; all state changes on rising edge.
REQ-007 Port rst  in  1  reset, synchronous, active-high.
REQ-008 Port ch_req  in  NCH  per-channel level request, held until that channel's ch_ack.
REQ-009 Port ch_addr  in  NCH*AW  per-channel address, ch i at bits [i*AW +: AW].
REQ-010 Port ch_ack  out  NCH  per-channel one-cycle completion pulse.
REQ-011 Port ch_err  out  NCH  per-channel one-cycle timeout flag, coincident with ch_ack.
REQ-012 Port ch_data  out  NCH*DW  per-channel result register, ch i at [i*DW +: DW].
REQ-013 Port co_req  out  1  downstream request, level.
REQ-014 Port co_addr  out  AW  downstream address, stable while co_req=1.
REQ-015 Port co_ack  in  1  downstream completion, sampled only in WAIT.
REQ-016 Port co_data  in  DW  downstream result, valid with co_ack.
REQ-017 Port busy  out  1  high whenever state != IDLE.
REQ-018 Port timeout_count  out  CW  saturating count of timed-out transactions.

Function
REQ-019 FSM states IDLE, WAIT, DONE; all outputs registered.
REQ-020 IDLE: if any ch_req, grant g = first requesting channel at or after rr_ptr, modulo NCH; latch g and ch_addr[g] into co_addr; co_req<=1; wait counter<=0; -> WAIT. No request: stay IDLE.
REQ-021 WAIT with co_ack=1: ch_data[g]<=co_data; ch_ack[g]<=1; co_req<=0; -> DONE.
REQ-022 WAIT, co_ack=0, counter==TIMEOUT-1: ch_ack[g]<=1, ch_err[g]<=1, ch_data[g] unchanged, co_req<=0, timeout_count+1 saturating at 2^CW-1; -> DONE.
REQ-023 WAIT otherwise: counter+1, co_req held 1; co_req is high for exactly TIMEOUT cycles on timeout.
REQ-024 co_ack on the same cycle as the timeout condition: ack wins, no error, no count.
REQ-025 DONE: ch_ack, ch_err <=0; rr_ptr<=(g+1) mod NCH; -> IDLE; ch_req ignored in DONE.
REQ-026 Requester rule: ch_req drops no later than the edge at which it samples ch_ack=1; DONE gap then prevents a double grant.
REQ-027 ch_req dropped during WAIT does not abort; the transaction completes or times out normally.
REQ-028 co_ack outside WAIT is ignored, no state change.
REQ-029 Latency: ch_req first seen in IDLE on edge t -> co_req high after t; co_ack sampled on edge t+k -> ch_ack high for the cycle after t+k; min request-to-ack 2 cycles.
REQ-030 At most one ch_ack bit high in any cycle; ch_data of non-granted channels never change.
REQ-031 NCH=1: rr_ptr constant 0; behaviour otherwise identical.

Reset
REQ-032 rst=1 at an edge, in any state: state<=IDLE, co_req=0, co_addr=0, ch_ack=0, ch_err=0, ch_data=0, rr_ptr=0, counter=0, timeout_count=0, busy=0.
REQ-033 Reset mid-WAIT: transaction dropped, no ch_ack; co_ack after reset with no new grant ignored.

Verification (NCH=2, TIMEOUT=8, CW=8)
REQ-034 ch_req=01, addr0=0x100; co_ack 3 cycles after co_req rises, co_data=0xABCD1234 -> co_addr=0x100, ch_ack=01 one cycle, ch_data0=0xABCD1234, ch_err=0.
REQ-035 ch_req=11 held from reset -> grants ch0 then ch1 (rr_ptr 0); after ch0 served, next simultaneous 11 grants ch1 first.
REQ-036 ch_req=10, co_ack never -> co_req high exactly 8 cycles, ch_ack=10 and ch_err=10 same cycle, timeout_count=1, ch_data1 unchanged.
REQ-037 co_ack coincident with 8th WAIT cycle, co_data=0x12345678 -> ch_err=0, ch_data=0x12345678, timeout_count unchanged.
REQ-038 rst pulsed during WAIT, then co_ack -> no ch_ack, all outputs at REQ-032 values, busy=0.
REQ-039 ch_req dropped mid-WAIT; co_ack arrives -> ch_ack still pulses, ch_data updated; back-to-back requester sees no double grant.
